// File: rtl/piano_pkg.sv
// Shared note constants and arpeggiator FSM state type.
// Imported by key_arpeggiator and arp_tick_gen.
package piano_pkg;
    localparam int         NUM_KEYS  = 12;
    localparam logic [3:0] NOTE_REST = 4'hF;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;
endpackage

// File: rtl/arp_tick_gen.sv
// Step-length prescaler: counts 0..TICK_DIV-1, pulses tick on the last count.
// A clr restarts the count from zero on the next edge.
module arp_tick_gen #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    import piano_pkg::*;

    localparam int W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == W'(TICK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || tick) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/key_arpeggiator.sv
// Key arpeggiator: cycles through held keys, one note per step.
// Define ARP_UPDOWN_EN for ping-pong order instead of up-only order.
module key_arpeggiator #(
    parameter int TICK_DIV = 100000,
    parameter int NUM_KEYS = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] keys,
    input  logic [2:0]          octave_in,
    input  logic [7:0]          step_len,
    output logic [3:0]          note,
    output logic [3:0]          octave,
    output logic                step,
    output logic                busy
);
    import piano_pkg::*;

    state_t              state_q, state_d;
    logic [NUM_KEYS-1:0] keys_q;
    logic [3:0]          note_q, note_d;
    logic [3:0]          oct_q, oct_d;
    logic [7:0]          len_q, len_d;
    logic [7:0]          scnt_q, scnt_d;
    logic                step_q, step_d;
    logic                clr, tick;
    logic [3:0]          nxt_note;

    // Key mask is MSB-first: bit NUM_KEYS-1-n holds note n.
    function automatic logic is_held(input logic [NUM_KEYS-1:0] k,
                                     input logic [3:0] n);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_KEYS; i++)
            if (int'(n) == i) r = k[NUM_KEYS-1-i];
        return r;
    endfunction

    function automatic logic [3:0] find_low(input logic [NUM_KEYS-1:0] k);
        logic [3:0] r;
        r = NOTE_REST;
        for (int i = NUM_KEYS - 1; i >= 0; i--)
            if (k[NUM_KEYS-1-i]) r = 4'(i);
        return r;
    endfunction

    function automatic logic [3:0] find_up(input logic [NUM_KEYS-1:0] k,
                                           input logic [3:0] cur);
        logic [3:0] r;
        r = NOTE_REST;
        for (int i = NUM_KEYS - 1; i >= 0; i--)
            if (k[NUM_KEYS-1-i] && i > int'(cur)) r = 4'(i);
        return r;
    endfunction

`ifdef ARP_UPDOWN_EN
    function automatic logic [3:0] find_down(input logic [NUM_KEYS-1:0] k,
                                             input logic [3:0] cur);
        logic [3:0] r;
        r = NOTE_REST;
        for (int i = 0; i < NUM_KEYS; i++)
            if (k[NUM_KEYS-1-i] && i < int'(cur)) r = 4'(i);
        return r;
    endfunction

    logic dir_q, dir_d, nxt_dir;
    logic [3:0] up_n, dn_n;

    always_comb begin
        up_n     = find_up(keys_q, note_q);
        dn_n     = find_down(keys_q, note_q);
        nxt_dir  = dir_q;
        nxt_note = find_low(keys_q);
        if (dir_q) begin
            if (up_n != NOTE_REST)      nxt_note = up_n;
            else if (dn_n != NOTE_REST) begin nxt_note = dn_n; nxt_dir = 1'b0; end
            else                        nxt_dir = 1'b0;
        end else begin
            if (dn_n != NOTE_REST)      nxt_note = dn_n;
            else if (up_n != NOTE_REST) begin nxt_note = up_n; nxt_dir = 1'b1; end
            else                        nxt_dir = 1'b1;
        end
    end
`else
    always_comb begin
        nxt_note = find_up(keys_q, note_q);
        if (nxt_note == NOTE_REST) nxt_note = find_low(keys_q);
    end
`endif

    arp_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        note_d  = note_q;
        oct_d   = oct_q;
        len_d   = len_q;
        scnt_d  = scnt_q;
        step_d  = 1'b0;
        clr     = 1'b0;
`ifdef ARP_UPDOWN_EN
        dir_d   = dir_q;
`endif
        unique case (state_q)
            IDLE: begin
                clr    = 1'b1;
                scnt_d = '0;
                note_d = NOTE_REST;
                if (keys_q != '0) begin
                    state_d = PLAY;
                    note_d  = find_low(keys_q);
                    step_d  = 1'b1;
                    oct_d   = {1'b0, octave_in};
                    len_d   = step_len;
`ifdef ARP_UPDOWN_EN
                    dir_d   = 1'b1;
`endif
                end
            end
            PLAY: begin
                if (keys_q == '0) begin
                    state_d = IDLE;
                    note_d  = NOTE_REST;
                    clr     = 1'b1;
                    scnt_d  = '0;
                // A dropped current key forces the boundary early.
                end else if ((tick && scnt_q == len_q) ||
                             !is_held(keys_q, note_q)) begin
                    note_d = nxt_note;
                    step_d = 1'b1;
                    oct_d  = {1'b0, octave_in};
                    len_d  = step_len;
                    clr    = 1'b1;
                    scnt_d = '0;
`ifdef ARP_UPDOWN_EN
                    dir_d  = nxt_dir;
`endif
                end else if (tick) begin
                    scnt_d = scnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            keys_q  <= '0;
            note_q  <= NOTE_REST;
            oct_q   <= '0;
            len_q   <= '0;
            scnt_q  <= '0;
            step_q  <= 1'b0;
`ifdef ARP_UPDOWN_EN
            dir_q   <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            keys_q  <= keys;
            note_q  <= note_d;
            oct_q   <= oct_d;
            len_q   <= len_d;
            scnt_q  <= scnt_d;
            step_q  <= step_d;
`ifdef ARP_UPDOWN_EN
            dir_q   <= dir_d;
`endif
        end
    end

    assign note   = note_q;
    assign octave = oct_q;
    assign step   = step_q;
    assign busy   = (state_q == PLAY);
endmodule

// File: tb/tb_key_arpeggiator.sv
// Self-checking bench for key_arpeggiator with TICK_DIV=4.
// Expected step events are queued at stimulus time and popped on each step pulse.
module tb_key_arpeggiator;
    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] keys;
    logic [2:0]  oct_in;
    logic [7:0]  len;
    logic [3:0]  note, octave;
    logic        step, busy;

    always #5 clk = ~clk;

    key_arpeggiator #(.TICK_DIV(TD), .NUM_KEYS(12)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .keys      (keys),
        .octave_in (oct_in),
        .step_len  (len),
        .note      (note),
        .octave    (octave),
        .step      (step),
        .busy      (busy)
    );

    typedef struct {
        logic [3:0] note;
        logic [3:0] oct;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [11:0] keys;
        logic [7:0]  len;
        logic [2:0]  oct;
        int          nst;
        logic [3:0]  seq [5];
    } vec_t;

    exp_t sbq[$];
    vec_t vt[4];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_steps = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Scoreboard consumer: every step pulse must match the queue head.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (step === 1'b1) begin
            n_steps++;
            if (sbq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_step: note %0d at cycle %0d, none expected",
                         note, cyc);
            end else begin
                e = sbq.pop_front();
                check("step_note", note, e.note);
                check("step_octave", octave, e.oct);
                check("step_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d steps outstanding after %0d cycles",
                     sbq.size(), n);
            sbq.delete();
        end
    endtask

    task automatic push(input logic [3:0] n, input logic [2:0] o, input int c);
        exp_t e;
        e.note = n;
        e.oct  = {1'b0, o};
        e.cyc  = c;
        sbq.push_back(e);
    endtask

    task automatic release_keys();
        keys = '0;
        @(negedge clk);
        check("busy_hold", busy, 1);
        @(negedge clk);
        check("rest_note", note, 4'hF);
        check("idle_busy", busy, 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int d, e, p, s0;

        vt[0].keys = 12'h890; vt[0].len = 8'd1; vt[0].oct = 3'd3; vt[0].nst = 5;
`ifdef ARP_UPDOWN_EN
        vt[0].seq  = '{4'd0, 4'd4, 4'd7, 4'd4, 4'd0};
`else
        vt[0].seq  = '{4'd0, 4'd4, 4'd7, 4'd0, 4'd4};
`endif
        vt[1].keys = 12'h001; vt[1].len = 8'd0; vt[1].oct = 3'd5; vt[1].nst = 4;
        vt[1].seq  = '{4'd11, 4'd11, 4'd11, 4'd11, 4'd11};
        vt[2].keys = 12'h204; vt[2].len = 8'd2; vt[2].oct = 3'd7; vt[2].nst = 4;
        vt[2].seq  = '{4'd2, 4'd9, 4'd2, 4'd9, 4'd2};
        vt[3].keys = 12'hFFF; vt[3].len = 8'd0; vt[3].oct = 3'd1; vt[3].nst = 5;
        vt[3].seq  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};

        // Reset with keys driven: outputs must still hold reset values.
        rst_n  = 1'b0;
        keys   = 12'h890;
        oct_in = 3'd7;
        len    = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_note", note, 4'hF);
        check("rst_octave", octave, 0);
        check("rst_step", step, 0);
        check("rst_busy", busy, 0);
        keys = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Idle with no keys for 20 cycles.
        s0 = n_steps;
        repeat (20) @(negedge clk);
        check("idle_note", note, 4'hF);
        check("idle_busy0", busy, 0);
        check("idle_steps", n_steps - s0, 0);

        // Table-driven note sequences.
        for (int v = 0; v < 4; v++) begin
            @(negedge clk);
            keys   = vt[v].keys;
            len    = vt[v].len;
            oct_in = vt[v].oct;
            d      = cyc;
            p      = (int'(vt[v].len) + 1) * TD;
            for (int j = 0; j < vt[v].nst; j++)
                push(vt[v].seq[j], vt[v].oct, d + 2 + j * p);
            drain(p * vt[v].nst + 10);
            release_keys();
        end

        // Drop the playing key: early boundary, counters restart.
        @(negedge clk);
        keys = 12'h890; len = 8'd1; oct_in = 3'd2; d = cyc;
        push(4'd0, 3'd2, d + 2);
        push(4'd4, 3'd2, d + 10);
        drain(30);
        keys = 12'h810; e = cyc;
        push(4'd7, 3'd2, e + 2);
        push(4'd0, 3'd2, e + 10);
        drain(30);
        release_keys();

        // Mid-step len/octave change waits for the next boundary.
        @(negedge clk);
        keys = 12'h204; len = 8'd0; oct_in = 3'd1; d = cyc;
        push(4'd2, 3'd1, d + 2);
        drain(10);
        e = cyc;
        len = 8'd2; oct_in = 3'd6;
        push(4'd9, 3'd6, e + 4);
        push(4'd2, 3'd6, e + 16);
        @(negedge clk);
        @(negedge clk);
        check("octave_hold", octave, 1);
        drain(30);
        release_keys();

        // One-cycle reset mid-step while keys stay held.
        @(negedge clk);
        keys = 12'h890; len = 8'd1; oct_in = 3'd4; d = cyc;
        push(4'd0, 3'd4, d + 2);
        drain(10);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_note", note, 4'hF);
        check("mid_rst_octave", octave, 0);
        check("mid_rst_step", step, 0);
        check("mid_rst_busy", busy, 0);
        rst_n = 1'b1;
        e = cyc;
        push(4'd0, 3'd4, e + 2);
        drain(10);
        release_keys();

        repeat (10) @(negedge clk);
        check("final_queue", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
